// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: machine word width, the
// canonical NOP that decode sees when no instruction is present, the default
// reset vector, the buffer entry layout and a word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // Width of the outstanding / drop counters. Responses in flight can exceed
    // DEPTH after a redirect, since stale requests stay outstanding while the
    // restarted stream issues new ones.
    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_ONE = 'd1;

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry circular buffer of fetches. An entry is allocated (with its PC)
// when the memory accepts a request, filled with the instruction word when
// the matching in-order response returns, and popped once filled.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   alloc_i/_pc_i     allocate the tail entry with this PC
//   fill_i/_data_i    fill the oldest unfilled entry with this word
//   pop_i             release the head entry
//   clear_i           drop every entry (redirect); overrides alloc/fill/pop
//   head_filled_o     head holds a word, including one being filled this cycle
//   head_pc_o         PC of the head entry
//   head_inst_o       word of the head entry (bypassed from fill_data_i)
//   count_o           number of allocated entries
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_i,
    input  logic [XLEN-1:0]         alloc_pc_i,
    input  logic                    fill_i,
    input  logic [XLEN-1:0]         fill_data_i,
    input  logic                    pop_i,
    input  logic                    clear_i,
    output logic                    head_filled_o,
    output logic [XLEN-1:0]         head_pc_o,
    output logic [XLEN-1:0]         head_inst_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 'd1;
    localparam logic [PW:0]   CNT_INC = 'd1;

    fetch_entry_t      entry_q [DEPTH];
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW-1:0]     fill_q, fill_d;
    logic [PW:0]       count_q, count_d;
    logic              head_fill_now;

    // A response landing on the head entry is forwarded straight to the
    // output so that a one-cycle memory sustains one instruction per cycle.
    assign head_fill_now = fill_i && (fill_q == head_q);
    assign head_filled_o = (count_q != '0) && (filled_q[head_q] || head_fill_now);
    assign head_pc_o     = entry_q[head_q].pc;
    assign head_inst_o   = filled_q[head_q] ? entry_q[head_q].inst : fill_data_i;
    assign count_o       = count_q;

    always_comb begin
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fill_d   = fill_q;
        count_d  = count_q;
        if (clear_i) begin
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fill_d   = '0;
            count_d  = '0;
        end else begin
            if (fill_i) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PTR_ONE;
            end
            // Pop after fill: a bypassed head frees its slot with filled=0.
            if (pop_i) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_ONE;
            end
            if (alloc_i) begin
                tail_d = tail_q + PTR_ONE;
            end
            count_d = count_q + (alloc_i ? CNT_INC : '0) - (pop_i ? CNT_INC : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
        end else begin
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives in filled_q/count_q.
    always_ff @(posedge clk_i) begin
        if (alloc_i && !clear_i) begin
            entry_q[tail_q].pc <= alloc_pc_i;
        end
        if (fill_i && !clear_i) begin
            entry_q[fill_q].inst <= fill_data_i;
        end
    end

endmodule

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction fetch stage. Owns the fetch PC, issues word requests to
// instruction memory (valid/ready, in-order responses), buffers returned
// words and presents {or_inst, or_pc, or_valid} to decode, holding them while
// decode stalls. A redirect from execute restarts fetch at a new PC and
// discards every fetch still in flight.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   ow_imem_req_valid    request valid (combinational from state + redirect)
//   i_imem_req_ready     memory accepts the request this cycle
//   or_imem_addr         request address (fetch PC), word aligned
//   i_imem_rsp_valid     in-order response valid
//   i_imem_rsp_data      response instruction word
//   i_stall              hold the decode-facing outputs
//   i_redirect           flush and restart at i_redirect_pc
//   i_redirect_pc        redirect target, low two bits ignored
//   or_inst/or_pc        instruction and its PC for decode
//   or_valid             or_inst/or_pc carry a real instruction
// -----------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            ow_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] or_imem_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic [XLEN-1:0]  opc_q, opc_d;

    logic             accept;
    logic             rsp_drop;
    logic             fill;
    logic             load;
    logic             pop;
    logic             head_filled;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_inst;
    logic [PW:0]      buf_count;

    assign ow_imem_req_valid = !i_redirect && (buf_count < DEPTH_C);
    assign accept            = ow_imem_req_valid && i_imem_req_ready;
    assign rsp_drop          = i_imem_rsp_valid && (drop_q != '0);
    // A response in a redirect cycle is stale by definition; it is counted
    // out of outst_q below and never reaches the buffer.
    assign fill              = i_imem_rsp_valid && (drop_q == '0) && !i_redirect;
    assign load              = !i_stall || !valid_q;
    assign pop               = !i_redirect && load && head_filled;

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk_i         (i_clk),
        .rst_ni        (i_rst_n),
        .alloc_i       (accept),
        .alloc_pc_i    (pc_q),
        .fill_i        (fill),
        .fill_data_i   (i_imem_rsp_data),
        .pop_i         (pop),
        .clear_i       (i_redirect),
        .head_filled_o (head_filled),
        .head_pc_o     (head_pc),
        .head_inst_o   (head_inst),
        .count_o       (buf_count)
    );

    always_comb begin
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = word_align(i_redirect_pc);
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // outst_q counts every accepted request not yet answered, stale or not.
    // On redirect all of them become stale, so the drop count is simply the
    // post-response outstanding count (no request is accepted that cycle).
    always_comb begin
        outst_d = outst_q;
        if (accept) begin
            outst_d = outst_d + CNT_ONE;
        end
        if (i_imem_rsp_valid) begin
            outst_d = outst_d - CNT_ONE;
        end
        drop_d = drop_q;
        if (i_redirect) begin
            drop_d = outst_d;
        end else if (rsp_drop) begin
            drop_d = drop_q - CNT_ONE;
        end
    end

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        if (i_redirect) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
        end else if (load) begin
            if (head_filled) begin
                valid_d = 1'b1;
                inst_d  = head_inst;
                opc_d   = head_pc;
            end else begin
                valid_d = 1'b0;
                inst_d  = INST_NOP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            opc_q   <= RESET_PC;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
        end
    end

    assign or_imem_addr = pc_q;
    assign or_inst      = inst_q;
    assign or_pc        = opc_q;
    assign or_valid     = valid_q;

    // Every response must belong to some accepted request.
    rsp_has_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ow_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] or_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [31:0] or_inst;
    logic [31:0] or_pc;
    logic        or_valid;

    fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .ow_imem_req_valid (ow_imem_req_valid),
        .i_imem_req_ready  (i_imem_req_ready),
        .or_imem_addr      (or_imem_addr),
        .i_imem_rsp_valid  (i_imem_rsp_valid),
        .i_imem_rsp_data   (i_imem_rsp_data),
        .i_stall           (i_stall),
        .i_redirect        (i_redirect),
        .i_redirect_pc     (i_redirect_pc),
        .or_inst           (or_inst),
        .or_pc             (or_pc),
        .or_valid          (or_valid)
    );

    always #5 clk = ~clk;

    // Reference model: fetches allocated since the last redirect (in order),
    // memory requests still pending (tagged with the redirect epoch that
    // issued them), and the per-cycle expected decode-side view.
    typedef struct { logic [31:0] pc; logic [31:0] inst; bit filled; } alloc_t;
    typedef struct { logic [31:0] data; int due; int epoch; } pend_t;
    typedef struct { bit valid; logic [31:0] pc; logic [31:0] inst; logic [31:0] addr; } rec_t;

    alloc_t aq[$];
    pend_t  pq[$];
    rec_t   sbq[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] mem_xor = '0;
    logic [31:0] next_pc = RPC;
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_inst = INST_NOP;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_xor;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        pq.delete();
        sbq.delete();
        next_pc  = RPC;
        m_valid  = 1'b0;
        m_pc     = RPC;
        m_inst   = INST_NOP;
        last_due = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, then predict what the
    // coming rising edge must produce.
    task automatic step(input bit rdy, input bit stl, input bit redir, input logic [31:0] rpc);
        bit reqv;
        bit acc;
        bit rsp;
        bit done;
        int l;
        int due;
        @(negedge clk);
        cyc++;
        i_imem_req_ready = rdy;
        i_stall          = stl;
        i_redirect       = redir;
        i_redirect_pc    = rpc;
        rsp              = (pq.size() > 0) && (pq[0].due <= cyc);
        i_imem_rsp_valid = rsp;
        i_imem_rsp_data  = rsp ? pq[0].data : $urandom;
        #1;
        reqv = !redir && (aq.size() < DEPTH);
        check("req_valid", 32'(ow_imem_req_valid), 32'(reqv));
        if (reqv) check("req_addr", or_imem_addr, next_pc);
        acc = reqv && rdy;
        if (rsp) begin
            if (pq[0].epoch == epoch) begin
                done = 1'b0;
                for (int i = 0; i < aq.size(); i++) begin
                    if (!done && !aq[i].filled) begin
                        aq[i].filled = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            void'(pq.pop_front());
        end
        if (redir) begin
            aq.delete();
            epoch++;
            next_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_inst  = INST_NOP;
        end else begin
            if (!stl || !m_valid) begin
                if (aq.size() > 0 && aq[0].filled) begin
                    m_valid = 1'b1;
                    m_pc    = aq[0].pc;
                    m_inst  = aq[0].inst;
                    void'(aq.pop_front());
                end else begin
                    m_valid = 1'b0;
                    m_inst  = INST_NOP;
                end
            end
            if (acc) begin
                aq.push_back('{next_pc, mem_word(next_pc), 1'b0});
                l   = $urandom_range(lat_max, lat_min);
                due = cyc + l;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pq.push_back('{mem_word(next_pc), due, epoch});
                next_pc = next_pc + 32'd4;
            end
        end
        sbq.push_back('{m_valid, m_pc, m_inst, next_pc});
    endtask

    // Monitor: compares the DUT's decode-facing view after every rising edge.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sbq.size() > 0) begin
                r = sbq.pop_front();
                check("or_valid", 32'(or_valid), 32'(r.valid));
                check("or_inst", or_inst, r.inst);
                if (r.valid) check("or_pc", or_pc, r.pc);
                check("imem_addr", or_imem_addr, r.addr);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(or_valid), 32'd0);
        check({tag, "_inst"}, or_inst, INST_NOP);
        check({tag, "_pc"}, or_pc, RPC);
        check({tag, "_addr"}, or_imem_addr, RPC);
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: streaming at L=1, word = address
        lat_min = 1; lat_max = 1; mem_xor = '0;
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
        @(posedge clk);
        #1;
        check("t1_valid", 32'(or_valid), 32'd1);
        check("t1_pc", or_pc, 32'h18);
        check("t1_inst", or_inst, 32'h18);

        // 2: stall mid-stream, then resume
        mem_xor = 32'hA5A5_0000;
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
        check("t2_full", 32'(ow_imem_req_valid), 32'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0);

        // 3: L=3, two in flight, redirect to 0x100
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pq.size() < 2; i++) step(1, 0, 0, '0);
        step(1, 0, 1, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, '0);
            @(posedge clk);
            #1;
            if (or_valid) begin
                found = 1'b1;
                check("t3_pc", or_pc, 32'h100);
                check("t3_inst", or_inst, mem_word(32'h100));
            end
        end
        if (!found) check("t3_timeout", 32'd0, 32'd1);

        // 4: redirect to unaligned target under stall with a same-cycle response
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 10 && !(pq.size() > 0 && pq[0].due <= cyc + 1); i++) step(1, 1, 0, '0);
        check("t4_rsp_due", 32'(pq.size() > 0 && pq[0].due <= cyc + 1), 32'd1);
        step(1, 1, 1, 32'h203);
        @(posedge clk);
        #1;
        check("t4_valid", 32'(or_valid), 32'd0);
        check("t4_addr", or_imem_addr, 32'h200);
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0);

        // 5: ready low for 5 cycles, then wrap at the top of the address space
        step(0, 0, 1, 32'h300);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, '0);
        @(posedge clk);
        #1;
        check("t5_wrap", or_imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0);

        // 6: asynchronous reset with fetches in flight and a valid output
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(m_valid && pq.size() >= 2); i++) step(1, 0, 0, '0);
        @(posedge clk);
        #2;
        check("t6_pre_valid", 32'(or_valid), 32'd1);
        rst_n = 1'b0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            mem_xor = (i % 100 == 0) ? $urandom : mem_xor;
            step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 20) == 0, $urandom);
        end

        // Drain: no new requests, everything in flight must come out
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0);
        @(posedge clk);
        #1;
        check("drain_valid", 32'(or_valid), 32'd0);
        check("drain_pending", 32'(aq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
